// File: rtl/lock_key_loader_if.sv
// Config-port bundle for the c432 key loader.
// Carries the serial key stream in and the key/status toward the core.
interface lock_key_loader_if #(
  parameter int MUX_KEY_W = 4,
  parameter int XOR_KEY_W = 11
);
  logic                 load_start;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 bit_ready;
  logic                 zeroize;
  logic [MUX_KEY_W-1:0] key_p;
  logic [XOR_KEY_W-1:0] key_x;
  logic                 key_valid;
  logic                 busy;
  logic                 key_err;

  modport master (
    output load_start, bit_valid, bit_in, zeroize,
    input  bit_ready, key_p, key_x, key_valid, busy, key_err
  );

  modport slave (
    input  load_start, bit_valid, bit_in, zeroize,
    output bit_ready, key_p, key_x, key_valid, busy, key_err
  );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432 core.
// Keys reach the core only after the nibble-fold checksum matches.
module lock_key_loader #(
  parameter int MUX_KEY_W = 4,
  parameter int XOR_KEY_W = 11,
  parameter int CHK_W     = 4
) (
  input logic            clk,
  input logic            rst,
  lock_key_loader_if.slave bus
);
  localparam int KEY_W = MUX_KEY_W + XOR_KEY_W;
  localparam int PAD_W = ((KEY_W + CHK_W - 1) / CHK_W) * CHK_W;
  localparam logic [3:0] KEY_LAST = 4'(KEY_W - 1);
  localparam logic [3:0] CHK_LAST = 4'(CHK_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_KEY,
    SHIFT_CHK,
    VERIFY,
    ARMED,
    FAULT
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [3:0]       cnt;
  logic [PAD_W-1:0] shadow;
  logic [CHK_W-1:0] chk_rx;
  logic [CHK_W-1:0] chk_calc;
  logic [KEY_W-1:0] key_q;
  logic             kv_q;
  logic             err_q;
  logic             rdy;
  logic             bsy;
  logic             clr;
  logic             accept;
  logic             match;

  // Fold the zero-padded shadow key into one checksum nibble.
  always_comb begin
    chk_calc = '0;
    for (int i = 0; i < PAD_W / CHK_W; i++) begin
      chk_calc = chk_calc ^ shadow[i*CHK_W +: CHK_W];
    end
  end

  assign match = (chk_calc == chk_rx);

  // Next state and handshake/status decode; zeroize beats load_start.
  always_comb begin
    nxt    = state;
    rdy    = 1'b0;
    bsy    = 1'b0;
    clr    = bus.zeroize | bus.load_start;
    accept = 1'b0;
    case (state)
      SHIFT_KEY: begin
        rdy = 1'b1;
        bsy = 1'b1;
      end
      SHIFT_CHK: begin
        rdy = 1'b1;
        bsy = 1'b1;
      end
      VERIFY: bsy = 1'b1;
      default: ;
    endcase
    accept = bus.bit_valid & rdy & ~clr;
    if (bus.zeroize) begin
      nxt = IDLE;
    end else if (bus.load_start) begin
      nxt = SHIFT_KEY;
    end else begin
      case (state)
        SHIFT_KEY: if (accept && cnt == KEY_LAST) nxt = SHIFT_CHK;
        SHIFT_CHK: if (accept && cnt == CHK_LAST) nxt = VERIFY;
        VERIFY:    nxt = match ? ARMED : FAULT;
        default:   ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Shift datapath, verified key and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= '0;
      chk_rx <= '0;
      key_q  <= '0;
      kv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      kv_q <= (nxt == ARMED);
      if (clr) begin
        cnt    <= '0;
        shadow <= '0;
        chk_rx <= '0;
        key_q  <= '0;
        err_q  <= 1'b0;
      end else begin
        if (accept && state == SHIFT_KEY) begin
          shadow[cnt] <= bus.bit_in;
          cnt <= (cnt == KEY_LAST) ? 4'd0 : cnt + 4'd1;
        end
        if (accept && state == SHIFT_CHK) begin
          chk_rx[cnt[1:0]] <= bus.bit_in;
          cnt <= (cnt == CHK_LAST) ? 4'd0 : cnt + 4'd1;
        end
        if (state == VERIFY) begin
          if (match) key_q <= shadow[KEY_W-1:0];
          else       err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bit_ready = rdy;
  assign bus.busy      = bsy;
  assign bus.key_valid = kv_q;
  assign bus.key_err   = err_q;
  assign bus.key_p     = key_q[MUX_KEY_W-1:0];
  assign bus.key_x     = key_q[KEY_W-1:MUX_KEY_W];

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader.
// Expected arm/fault outcomes are queued per load and popped on result.
module tb_lock_key_loader;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lock_key_loader_if bus ();

  lock_key_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ok;
    logic [14:0] key;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] csum(input logic [14:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 15; i++) c[i % 4] = c[i % 4] ^ k[i];
    return c;
  endfunction

  function automatic logic [31:0] snap();
    return {13'd0, bus.bit_ready, bus.busy, bus.key_valid,
            bus.key_err, bus.key_p, bus.key_x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_kv", bus.key_valid, 0);
    check("start_keys", {bus.key_p, bus.key_x}, 0);
  endtask

  task automatic shift(input logic [14:0] k, input logic [3:0] c,
                       input int gap);
    exp_t e;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) repeat (gap) tick();
      bus.bit_valid = 1'b1;
      bus.bit_in    = (i < 15) ? k[i] : c[i-15];
      tick();
      bus.bit_valid = 1'b0;
    end
    e.ok  = (c == csum(k));
    e.key = k;
    sb.push_back(e);
    check("verify_state", {bus.busy, bus.bit_ready, bus.key_valid}, 3'b100);
  endtask

  task automatic result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.key_valid && !bus.key_err && n < 8) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 0, 1);
    end else begin
      e = sb.pop_front();
      if (!bus.key_valid && !bus.key_err) begin
        check({tag, "_timeout"}, 0, 1);
      end else begin
        check({tag, "_lat"}, n, 1);
        check({tag, "_kv"}, bus.key_valid, e.ok);
        check({tag, "_err"}, bus.key_err, !e.ok);
        check({tag, "_p"}, bus.key_p, e.ok ? e.key[3:0] : 4'd0);
        check({tag, "_x"}, bus.key_x, e.ok ? e.key[14:4] : 11'd0);
        check({tag, "_busy"}, bus.busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.zeroize    = 1'b0;
    #12 rst = 1'b0;
    repeat (10) tick();
    check("reset_idle", snap(), 0);

    start();
    shift(15'h1234, 4'h4, 0);
    result("arm1");
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    repeat (3) tick();
    bus.bit_valid = 1'b0;
    check("armed_hold", {bus.key_valid, bus.key_p, bus.key_x},
          {1'b1, 4'h4, 11'h123});

    start();
    shift(15'h1234, 4'h5, 0);
    result("bad");
    bus.bit_valid = 1'b1;
    repeat (20) tick();
    bus.bit_valid = 1'b0;
    check("fault_hold", snap(), 32'h8000);
    start();
    check("err_clr", bus.key_err, 0);

    shift(15'h1234, 4'h4, 0);
    result("arm2");
    start();
    shift(15'h7FFF, 4'h8, 0);
    result("arm_ff");

    start();
    for (int i = 0; i < 7; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = i[0];
      tick();
    end
    bus.bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", snap(), 0);
    #2 rst = 1'b0;
    tick();
    start();
    shift(15'h0001, 4'h1, 0);
    result("post_rst");

    bus.zeroize    = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.zeroize    = 1'b0;
    bus.load_start = 1'b0;
    check("zeroize", snap(), 0);
    bus.load_start = 1'b1;
    bus.bit_valid  = 1'b1;
    bus.bit_in     = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    check("ls_bv_busy", bus.busy, 1);
    shift(15'h2A5A, csum(15'h2A5A), 1);
    result("discard");

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
